// File: rtl/crank_wheel_emulator.sv
// N-M toothed crank wheel generator: square tooth train of period P with M missing teeth per revolution.
// Latency: 1 clk from enable sampled high to the tooth 0 rise. No backpressure; free-running while enabled.
module crank_wheel_emulator #(
  parameter int WIDTH  = 24,
  parameter int TWIDTH = 8
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              enable,
  input  logic [WIDTH-1:0]  tooth_period,
  input  logic [TWIDTH-1:0] teeth_total,
  input  logic [TWIDTH-1:0] teeth_missing,
  output logic              crank,
  output logic [TWIDTH-1:0] tooth_num,
  output logic              gap_active,
  output logic              rev_strobe,
  output logic              cfg_err
);

  typedef enum logic [1:0] {IDLE, TOOTH_HI, TOOTH_LO, GAP} state_t;

  state_t            state, state_d;
  logic [WIDTH-1:0]  cnt, cnt_d, p_reg, p_d, p_in, lo_len;
  logic [TWIDTH-1:0] n_reg, n_d, m_reg, m_d, miss, miss_d, tooth_d, last_tooth;
  logic              crank_d, gap_d, rev_d, cfg_err_d, cfg_ok;

  assign p_in       = (tooth_period < WIDTH'(2)) ? WIDTH'(2) : tooth_period;
  assign cfg_ok     = (teeth_total >= TWIDTH'(2)) && (teeth_missing >= TWIDTH'(1)) &&
                      (teeth_missing < teeth_total);
  assign lo_len     = p_reg - (p_reg >> 1);
  assign last_tooth = n_reg - m_reg - TWIDTH'(1);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      cnt        <= '0;
      p_reg      <= '0;
      n_reg      <= '0;
      m_reg      <= '0;
      miss       <= '0;
      tooth_num  <= '0;
      crank      <= 1'b0;
      gap_active <= 1'b0;
      rev_strobe <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      p_reg      <= p_d;
      n_reg      <= n_d;
      m_reg      <= m_d;
      miss       <= miss_d;
      tooth_num  <= tooth_d;
      crank      <= crank_d;
      gap_active <= gap_d;
      rev_strobe <= rev_d;
      cfg_err    <= cfg_err_d;
    end
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    p_d       = p_reg;
    n_d       = n_reg;
    m_d       = m_reg;
    miss_d    = miss;
    tooth_d   = tooth_num;
    crank_d   = crank;
    gap_d     = gap_active;
    rev_d     = 1'b0;
    cfg_err_d = cfg_err;
    case (state)
      IDLE: begin
        cfg_err_d = !cfg_ok;
        crank_d   = 1'b0;
        gap_d     = 1'b0;
        tooth_d   = '0;
        if (enable && cfg_ok) begin
          state_d = TOOTH_HI;
          crank_d = 1'b1;
          rev_d   = 1'b1;
          p_d     = p_in;
          n_d     = teeth_total;
          m_d     = teeth_missing;
          cnt_d   = (p_in >> 1) - WIDTH'(1);
        end
      end
      TOOTH_HI: begin
        if (cnt == '0) begin
          state_d = TOOTH_LO;
          crank_d = 1'b0;
          cnt_d   = lo_len - WIDTH'(1);
        end else begin
          cnt_d = cnt - WIDTH'(1);
        end
      end
      TOOTH_LO: begin
        if (cnt != '0) begin
          cnt_d = cnt - WIDTH'(1);
        end else if (tooth_num < last_tooth) begin
          state_d = TOOTH_HI;
          tooth_d = tooth_num + TWIDTH'(1);
          crank_d = 1'b1;
          p_d     = p_in;
          cnt_d   = (p_in >> 1) - WIDTH'(1);
        end else begin
          // Gap length is M whole periods: cnt times one period, miss counts periods.
          state_d = GAP;
          gap_d   = 1'b1;
          p_d     = p_in;
          cnt_d   = p_in - WIDTH'(1);
          miss_d  = m_reg - TWIDTH'(1);
        end
      end
      GAP: begin
        if (cnt != '0) begin
          cnt_d = cnt - WIDTH'(1);
        end else if (miss != '0) begin
          miss_d = miss - TWIDTH'(1);
          cnt_d  = p_reg - WIDTH'(1);
        end else begin
          state_d = TOOTH_HI;
          tooth_d = '0;
          crank_d = 1'b1;
          rev_d   = 1'b1;
          gap_d   = 1'b0;
          p_d     = p_in;
          cnt_d   = (p_in >> 1) - WIDTH'(1);
          // A bad wheel config mid-run is ignored; the last good N/M stays in force.
          if (cfg_ok) begin
            n_d = teeth_total;
            m_d = teeth_missing;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (state != IDLE && !enable) begin
      state_d = IDLE;
      crank_d = 1'b0;
      gap_d   = 1'b0;
      rev_d   = 1'b0;
      tooth_d = '0;
      cnt_d   = '0;
      miss_d  = '0;
    end
  end

endmodule

// File: tb/tb_crank_wheel_emulator.sv
// Directed stimulus with a scoreboard: expected crank edges and timed signal samples are
// queued by the stimulus and compared by a separate negedge monitor.
module tb_crank_wheel_emulator;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       enable = 1'b0;
  logic [23:0] tooth_period = 24'd10;
  logic [7:0] teeth_total = 8'd6;
  logic [7:0] teeth_missing = 8'd2;
  logic       crank, gap_active, rev_strobe, cfg_err;
  logic [7:0] tooth_num;

  crank_wheel_emulator #(.WIDTH(24), .TWIDTH(8)) dut (
    .clk(clk), .n_rst(n_rst), .enable(enable), .tooth_period(tooth_period),
    .teeth_total(teeth_total), .teeth_missing(teeth_missing), .crank(crank),
    .tooth_num(tooth_num), .gap_active(gap_active), .rev_strobe(rev_strobe), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int cyc; bit rise; int tooth; bit rev; bit gap;} edge_t;
  typedef struct {int cyc; int sig; int val;} smp_t;
  localparam int S_CRANK = 0, S_TOOTH = 1, S_GAP = 2, S_REV = 3, S_CFG = 4;

  edge_t edge_q[$];
  smp_t  smp_q[$];
  int    checks = 0;
  int    errors = 0;
  bit    done = 1'b0;
  bit    fin = 1'b0;
  logic  prev_crank = 1'b0;

  function automatic int sig_val(int s);
    case (s)
      S_CRANK: return int'(crank);
      S_TOOTH: return int'(tooth_num);
      S_GAP:   return int'(gap_active);
      S_REV:   return int'(rev_strobe);
      default: return int'(cfg_err);
    endcase
  endfunction

  function automatic string sig_name(int s);
    case (s)
      S_CRANK: return "crank";
      S_TOOTH: return "tooth_num";
      S_GAP:   return "gap_active";
      S_REV:   return "rev_strobe";
      default: return "cfg_err";
    endcase
  endfunction

  task automatic exp_edge(int c, bit r, int t, bit rv, bit g);
    edge_q.push_back('{cyc: c, rise: r, tooth: t, rev: rv, gap: g});
  endtask

  task automatic exp_smp(int c, int s, int v);
    smp_q.push_back('{cyc: c, sig: s, val: v});
  endtask

  task automatic go_to(int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: compares crank edges and due samples against the queued expectations.
  always @(negedge clk) begin
    edge_t e;
    smp_t  s;
    int    act;
    if (crank !== prev_crank) begin
      checks++;
      if (edge_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_edge cyc=%0d crank=%b tooth=%0d", cyc, crank, tooth_num);
      end else begin
        e = edge_q.pop_front();
        if (e.cyc != cyc || e.rise != crank || e.tooth != int'(tooth_num) ||
            e.rev != rev_strobe || e.gap != gap_active)
        begin
          errors++;
          $display("FAIL crank_edge got cyc=%0d rise=%b tooth=%0d rev=%b gap=%b exp cyc=%0d rise=%b tooth=%0d rev=%b gap=%b",
                   cyc, crank, tooth_num, rev_strobe, gap_active, e.cyc, e.rise, e.tooth, e.rev, e.gap);
        end
      end
    end
    prev_crank = crank;
    while (smp_q.size() > 0 && smp_q[0].cyc <= cyc) begin
      s = smp_q.pop_front();
      act = sig_val(s.sig);
      checks++;
      if (s.cyc != cyc || act != s.val) begin
        errors++;
        $display("FAIL %s cyc=%0d got=%0d exp=%0d due_cyc=%0d", sig_name(s.sig), cyc, act, s.val, s.cyc);
      end
    end
    if (done && !fin) begin
      checks++;
      if (edge_q.size() != 0 || smp_q.size() != 0) begin
        errors++;
        $display("FAIL leftover_expectations got edges=%0d samples=%0d exp 0 0", edge_q.size(), smp_q.size());
      end
      fin = 1'b1;
    end
  end

  initial begin
    int c, r;
    // Reset state, sampled while n_rst is still low.
    exp_smp(1, S_CRANK, 0); exp_smp(1, S_TOOTH, 0); exp_smp(1, S_GAP, 0);
    exp_smp(1, S_REV, 0);   exp_smp(1, S_CFG, 0);
    go_to(2);
    n_rst = 1'b1;
    go_to(4);

    // 60-2 style wheel scaled down: P=10, N=6, M=2; two revolutions, drop in gap, restart.
    c = cyc;
    enable = 1'b1;
    for (int k = 0; k < 2; k++) begin
      for (int t = 0; t < 4; t++) begin
        exp_edge(c + 1 + 60*k + 10*t, 1'b1, t, t == 0, 1'b0);
        exp_edge(c + 6 + 60*k + 10*t, 1'b0, t, 1'b0, 1'b0);
      end
    end
    exp_edge(c + 111, 1'b1, 0, 1'b1, 1'b0);
    exp_edge(c + 116, 1'b0, 0, 1'b0, 1'b0);
    exp_smp(c + 2, S_REV, 0);
    exp_smp(c + 40, S_GAP, 0);
    exp_smp(c + 41, S_GAP, 1);
    exp_smp(c + 41, S_TOOTH, 3);
    exp_smp(c + 60, S_GAP, 1);
    exp_smp(c + 60, S_TOOTH, 3);
    exp_smp(c + 62, S_REV, 0);
    exp_smp(c + 105, S_GAP, 1);
    exp_smp(c + 106, S_GAP, 0);
    exp_smp(c + 106, S_TOOTH, 0);
    exp_smp(c + 106, S_CRANK, 0);
    exp_smp(c + 110, S_REV, 0);
    go_to(c + 105); enable = 1'b0;
    go_to(c + 110); enable = 1'b1;
    go_to(c + 118); enable = 1'b0;
    go_to(c + 121);

    // Odd period splits 3 high / 4 low.
    c = cyc;
    tooth_period = 24'd7;
    enable = 1'b1;
    exp_edge(c + 1, 1'b1, 0, 1'b1, 1'b0);
    exp_edge(c + 4, 1'b0, 0, 1'b0, 1'b0);
    exp_edge(c + 8, 1'b1, 1, 1'b0, 1'b0);
    exp_edge(c + 11, 1'b0, 1, 1'b0, 1'b0);
    go_to(c + 12); enable = 1'b0;
    go_to(c + 14);

    // Periods 0 and 1 clamp to 2: one cycle high, one low.
    for (int pv = 0; pv < 2; pv++) begin
      c = cyc;
      tooth_period = 24'(pv);
      enable = 1'b1;
      exp_edge(c + 1, 1'b1, 0, 1'b1, 1'b0);
      exp_edge(c + 2, 1'b0, 0, 1'b0, 1'b0);
      exp_edge(c + 3, 1'b1, 1, 1'b0, 1'b0);
      exp_edge(c + 4, 1'b0, 1, 1'b0, 1'b0);
      go_to(c + 4); enable = 1'b0;
      go_to(c + 6);
    end

    // Period change 10 -> 20 mid high phase of tooth 1 takes effect from tooth 2; gap is 2*20.
    c = cyc;
    tooth_period = 24'd10;
    enable = 1'b1;
    exp_edge(c + 1, 1'b1, 0, 1'b1, 1'b0);
    exp_edge(c + 6, 1'b0, 0, 1'b0, 1'b0);
    exp_edge(c + 11, 1'b1, 1, 1'b0, 1'b0);
    exp_edge(c + 16, 1'b0, 1, 1'b0, 1'b0);
    exp_edge(c + 21, 1'b1, 2, 1'b0, 1'b0);
    exp_edge(c + 31, 1'b0, 2, 1'b0, 1'b0);
    exp_edge(c + 41, 1'b1, 3, 1'b0, 1'b0);
    exp_edge(c + 51, 1'b0, 3, 1'b0, 1'b0);
    exp_edge(c + 101, 1'b1, 0, 1'b1, 1'b0);
    exp_edge(c + 103, 1'b0, 0, 1'b0, 1'b0);
    exp_smp(c + 60, S_GAP, 0);
    exp_smp(c + 61, S_GAP, 1);
    exp_smp(c + 100, S_GAP, 1);
    go_to(c + 13); tooth_period = 24'd20;
    go_to(c + 102); enable = 1'b0;
    go_to(c + 105);

    // Invalid configs hold the wheel idle; a valid one starts it; cfg_err frozen while running.
    c = cyc;
    tooth_period = 24'd10;
    teeth_total = 8'd4;
    teeth_missing = 8'd4;
    exp_smp(c + 1, S_CFG, 1);
    exp_smp(c + 4, S_CRANK, 0);
    exp_smp(c + 5, S_CFG, 1);
    exp_smp(c + 5, S_CRANK, 0);
    r = c + 6;
    exp_edge(r + 1, 1'b1, 0, 1'b1, 1'b0);
    exp_edge(r + 6, 1'b0, 0, 1'b0, 1'b0);
    exp_edge(r + 11, 1'b1, 1, 1'b0, 1'b0);
    exp_edge(r + 16, 1'b0, 1, 1'b0, 1'b0);
    exp_edge(r + 21, 1'b1, 2, 1'b0, 1'b0);
    exp_edge(r + 26, 1'b0, 2, 1'b0, 1'b0);
    exp_edge(r + 41, 1'b1, 0, 1'b1, 1'b0);
    exp_edge(r + 43, 1'b0, 0, 1'b0, 1'b0);
    exp_smp(r + 1, S_CFG, 0);
    exp_smp(r + 31, S_GAP, 1);
    exp_smp(r + 38, S_CFG, 0);
    exp_smp(r + 44, S_CFG, 1);
    go_to(c + 2); enable = 1'b1;
    go_to(c + 4); teeth_total = 8'd1; teeth_missing = 8'd1;
    go_to(r); teeth_total = 8'd4; teeth_missing = 8'd1;
    go_to(r + 35); teeth_total = 8'd1;
    go_to(r + 42); enable = 1'b0;
    go_to(r + 45);
    teeth_total = 8'd6;
    teeth_missing = 8'd2;

    // Async reset mid high phase of tooth 1, then restart with the same timing as the first run.
    c = cyc;
    enable = 1'b1;
    exp_edge(c + 1, 1'b1, 0, 1'b1, 1'b0);
    exp_edge(c + 6, 1'b0, 0, 1'b0, 1'b0);
    exp_edge(c + 11, 1'b1, 1, 1'b0, 1'b0);
    exp_edge(c + 13, 1'b0, 0, 1'b0, 1'b0);
    exp_smp(c + 13, S_CRANK, 0); exp_smp(c + 13, S_TOOTH, 0); exp_smp(c + 13, S_GAP, 0);
    exp_smp(c + 13, S_REV, 0);   exp_smp(c + 13, S_CFG, 0);
    r = c + 15;
    for (int t = 0; t < 4; t++) begin
      exp_edge(r + 10*t, 1'b1, t, t == 0, 1'b0);
      exp_edge(r + 5 + 10*t, 1'b0, t, 1'b0, 1'b0);
    end
    exp_edge(r + 60, 1'b1, 0, 1'b1, 1'b0);
    exp_edge(r + 62, 1'b0, 0, 1'b0, 1'b0);
    exp_smp(r + 40, S_GAP, 1);
    exp_smp(r + 59, S_GAP, 1);
    go_to(c + 12);
    @(posedge clk);
    #2 n_rst = 1'b0;
    go_to(c + 14); n_rst = 1'b1;
    go_to(r + 61); enable = 1'b0;
    go_to(r + 64);

    done = 1'b1;
    for (int i = 0; i < 5 && !fin; i++) @(negedge clk);
    #1;
    if (!fin) begin
      errors++;
      $display("FAIL monitor_finish got fin=0 exp fin=1");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
